writeback_unit: RTL and testbench

Write-side master for the CPU register file: collects results from the single-cycle ALU and the variable-latency load unit, arbitrates them onto the register file's single write port, and keeps a per-register busy scoreboard that stalls issue on RAW/WAW hazards. It sits between the execute/memory stages and the register file's `writeEnable`/`writeReg`/`writeData` inputs. It also drives the issue-stage stall, so an instruction only reads operands once their register-file writes have committed.

---
 rtl/writeback_unit.sv | 155 +++++++++++++++
 tb/tb_writeback_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// Register-file write-side master: merges ALU and load results onto one write port
// and keeps the per-register busy scoreboard that stalls issue on RAW/WAW hazards.
module writeback_unit #(
  parameter int XLEN      = 32,
  parameter int LDQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rs1,
  input  logic [4:0]      issue_rs2,
  input  logic [4:0]      issue_rd,
  output logic            issue_stall,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            reg_we,
  output logic [4:0]      reg_waddr,
  output logic [XLEN-1:0] reg_wdata,
  output logic            err
);

  localparam int PTR_W = $clog2(LDQ_DEPTH);
  localparam int CNT_W = $clog2(LDQ_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LDQ_DEPTH);

  logic [31:0]       busy_q, busy_d;
  logic [4:0]        ldq_rd_q   [LDQ_DEPTH];
  logic [XLEN-1:0]   ldq_data_q [LDQ_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              reg_we_q, reg_we_d;
  logic [4:0]        reg_waddr_q, reg_waddr_d;
  logic [XLEN-1:0]   reg_wdata_q, reg_wdata_d;
  logic              err_q, err_d;

  logic              issue_acc_s, ld_xfer_s, push_s, pop_s, sel_valid_s;
  logic [4:0]        sel_rd_s;
  logic [XLEN-1:0]   sel_data_s;

  assign issue_stall = issue_valid & (busy_q[issue_rs1] | busy_q[issue_rs2] | busy_q[issue_rd]);
  assign issue_acc_s = issue_valid & ~issue_stall;
  assign ld_ready    = (count_q < DEPTH_C);
  assign ld_xfer_s   = ld_valid & ld_ready;

  assign reg_we    = reg_we_q;
  assign reg_waddr = reg_waddr_q;
  assign reg_wdata = reg_wdata_q;
  assign err       = err_q;

  // Strict-priority source selection: ALU, then FIFO head, then same-cycle load bypass.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_rd_s    = 5'd0;
    sel_data_s  = '0;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    if (alu_valid) begin
      sel_valid_s = 1'b1;
      sel_rd_s    = alu_rd;
      sel_data_s  = alu_data;
      push_s      = ld_xfer_s;
    end else if (count_q != '0) begin
      sel_valid_s = 1'b1;
      sel_rd_s    = ldq_rd_q[rd_ptr_q];
      sel_data_s  = ldq_data_q[rd_ptr_q];
      pop_s       = 1'b1;
      push_s      = ld_xfer_s;
    end else if (ld_xfer_s) begin
      sel_valid_s = 1'b1;
      sel_rd_s    = ld_rd;
      sel_data_s  = ld_data;
    end else begin
      sel_valid_s = 1'b0;
    end
  end

  // FIFO pointer/count and write-port next-state.
  always_comb begin
    wr_ptr_d = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    reg_we_d = sel_valid_s & (sel_rd_s != 5'd0);
    if (sel_valid_s) begin
      reg_waddr_d = sel_rd_s;
      reg_wdata_d = sel_data_s;
    end else begin
      reg_waddr_d = reg_waddr_q;
      reg_wdata_d = reg_wdata_q;
    end
  end

  // Scoreboard: commit clears, accepted issue sets afterwards so set wins on a collision.
  always_comb begin
    busy_d = busy_q;
    err_d  = err_q;
    if (reg_we_q) begin
      err_d = err_q | ~busy_q[reg_waddr_q];
      busy_d[reg_waddr_q] = 1'b0;
    end else begin
      err_d = err_q;
    end
    if (issue_acc_s && (issue_rd != 5'd0)) begin
      busy_d[issue_rd] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
  end

  // Control state: scoreboard, FIFO pointers, write port and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= 32'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      reg_we_q    <= 1'b0;
      reg_waddr_q <= 5'd0;
      reg_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      reg_we_q    <= reg_we_d;
      reg_waddr_q <= reg_waddr_d;
      reg_wdata_q <= reg_wdata_d;
      err_q       <= err_d;
    end
  end

  // Load FIFO storage; cleared on reset so no stale result can ever resurface.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LDQ_DEPTH; i++) begin
        ldq_rd_q[i]   <= 5'd0;
        ldq_data_q[i] <= '0;
      end
    end else if (push_s) begin
      ldq_rd_q[wr_ptr_q]   <= ld_rd;
      ldq_data_q[wr_ptr_q] <= ld_data;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: vector table for single-cycle behaviour plus
// hand sequences for backpressure and asynchronous mid-stream reset.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_stall;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        reg_we;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        err;

  int checks   = 0;
  int failures = 0;

  writeback_unit #(.XLEN(32), .LDQ_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_stall(issue_stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [4:0]  rs1, rs2, rd;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adata;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldata;
    logic        stall, ldr, we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        err;
  } vec_t;

  vec_t vt[20];

  function automatic vec_t mk(logic iv, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                              logic av, logic [4:0] ard, logic [31:0] adata,
                              logic lv, logic [4:0] lrd, logic [31:0] ldata,
                              logic stall, logic ldr, logic we, logic [4:0] waddr,
                              logic [31:0] wdata, logic e);
    vec_t v;
    v.iv = iv; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.av = av; v.ard = ard; v.adata = adata;
    v.lv = lv; v.lrd = lrd; v.ldata = ldata;
    v.stall = stall; v.ldr = ldr; v.we = we; v.waddr = waddr; v.wdata = wdata; v.err = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_rd = 5'd0;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'd0;
  endtask

  task automatic do_issue(input logic [4:0] rd);
    issue_valid = 1'b1; issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_rd = rd;
    #1;
    chk($sformatf("issue_rd%0d_stall", rd), {31'd0, issue_stall}, 32'd0);
    tick();
    issue_valid = 1'b0;
  endtask

  initial begin
    // ALU RAW on x3, ALU/load conflict, x0 consumption, WAW stall, and err on a non-busy commit
    vt[0]  = mk(1'b1, 5'd0, 5'd0, 5'd3, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b0, 5'd0,  32'h0,        1'b0);
    vt[1]  = mk(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        1'b0);
    vt[2]  = mk(1'b1, 5'd3, 5'd0, 5'd0, 1'b1, 5'd3,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd3,  32'hDEADBEEF, 1'b0);
    vt[3]  = mk(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd3,  32'hDEADBEEF, 1'b0);
    vt[4]  = mk(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b0, 5'd3,  32'hDEADBEEF, 1'b0);
    vt[5]  = mk(1'b1, 5'd0, 5'd0, 5'd4, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b0, 5'd3,  32'hDEADBEEF, 1'b0);
    vt[6]  = mk(1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b0, 5'd3,  32'hDEADBEEF, 1'b0);
    vt[7]  = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd4,  32'h44,       1'b1, 5'd7, 32'h77, 1'b0, 1'b1, 1'b1, 5'd4,  32'h44,       1'b0);
    vt[8]  = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b1, 5'd7,  32'h77,       1'b0);
    vt[9]  = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b0, 5'd7,  32'h77,       1'b0);
    vt[10] = mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0,  32'h55,       1'b1, 5'd0, 32'h66, 1'b0, 1'b1, 1'b0, 5'd0,  32'h55,       1'b0);
    vt[11] = mk(1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b0, 5'd0,  32'h66,       1'b0);
    vt[12] = mk(1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b0, 5'd0,  32'h66,       1'b0);
    vt[13] = mk(1'b1, 5'd0, 5'd9, 5'd0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd0,  32'h66,       1'b0);
    vt[14] = mk(1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd0,  32'h66,       1'b0);
    vt[15] = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd9,  32'h99,       1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b1, 5'd9,  32'h99,       1'b0);
    vt[16] = mk(1'b1, 5'd0, 5'd9, 5'd0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd9,  32'h99,       1'b0);
    vt[17] = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd12, 32'hC,        1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b1, 5'd12, 32'hC,        1'b0);
    vt[18] = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b0, 5'd12, 32'hC,        1'b1);
    vt[19] = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b0, 5'd12, 32'hC,        1'b1);

    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("reset_ld_ready_async", {31'd0, ld_ready}, 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    chk("reset_reg_we",    {31'd0, reg_we}, 32'd0);
    chk("reset_reg_waddr", {27'd0, reg_waddr}, 32'd0);
    chk("reset_reg_wdata", reg_wdata, 32'd0);
    chk("reset_err",       {31'd0, err}, 32'd0);

    for (int i = 0; i < 20; i++) begin
      issue_valid = vt[i].iv; issue_rs1 = vt[i].rs1; issue_rs2 = vt[i].rs2; issue_rd = vt[i].rd;
      alu_valid = vt[i].av; alu_rd = vt[i].ard; alu_data = vt[i].adata;
      ld_valid = vt[i].lv; ld_rd = vt[i].lrd; ld_data = vt[i].ldata;
      #1;
      chk($sformatf("v%0d_issue_stall", i), {31'd0, issue_stall}, {31'd0, vt[i].stall});
      chk($sformatf("v%0d_ld_ready", i),    {31'd0, ld_ready},    {31'd0, vt[i].ldr});
      tick();
      chk($sformatf("v%0d_reg_we", i),    {31'd0, reg_we},    {31'd0, vt[i].we});
      chk($sformatf("v%0d_reg_waddr", i), {27'd0, reg_waddr}, {27'd0, vt[i].waddr});
      chk($sformatf("v%0d_reg_wdata", i), reg_wdata,          vt[i].wdata);
      chk($sformatf("v%0d_err", i),       {31'd0, err},       {31'd0, vt[i].err});
    end
    idle_inputs();

    // Backpressure: 5 ALU cycles starve loads 8,9,10; FIFO fills after two accepts
    do_issue(5'd8); do_issue(5'd9); do_issue(5'd10);
    for (int k = 0; k < 5; k++) do_issue(5'(20 + k));
    for (int k = 0; k < 5; k++) begin
      alu_valid = 1'b1; alu_rd = 5'(20 + k); alu_data = 32'(k);
      ld_valid = 1'b1;
      ld_rd = (k == 0) ? 5'd8 : ((k == 1) ? 5'd9 : 5'd10);
      ld_data = 32'h800 + 32'(ld_rd);
      #1;
      chk($sformatf("bp_alu%0d_ld_ready", k), {31'd0, ld_ready}, (k < 2) ? 32'd1 : 32'd0);
      tick();
      chk($sformatf("bp_alu%0d_we", k),    {31'd0, reg_we},    32'd1);
      chk($sformatf("bp_alu%0d_waddr", k), {27'd0, reg_waddr}, 32'(20 + k));
    end
    alu_valid = 1'b0;
    #1;
    chk("bp_idle0_ld_ready", {31'd0, ld_ready}, 32'd0);
    tick();
    chk("bp_w8_waddr", {27'd0, reg_waddr}, 32'd8);
    chk("bp_w8_wdata", reg_wdata, 32'h808);
    chk("bp_w8_we", {31'd0, reg_we}, 32'd1);
    chk("bp_idle1_ld_ready", {31'd0, ld_ready}, 32'd1);
    tick();
    ld_valid = 1'b0;
    chk("bp_w9_waddr", {27'd0, reg_waddr}, 32'd9);
    chk("bp_w9_wdata", reg_wdata, 32'h809);
    tick();
    chk("bp_w10_waddr", {27'd0, reg_waddr}, 32'd10);
    chk("bp_w10_wdata", reg_wdata, 32'h80A);
    chk("bp_w10_we", {31'd0, reg_we}, 32'd1);
    tick();
    chk("bp_drained_we", {31'd0, reg_we}, 32'd0);
    issue_valid = 1'b1; issue_rs1 = 5'd10; issue_rs2 = 5'd8; issue_rd = 5'd9;
    #1;
    chk("bp_regs_free_stall", {31'd0, issue_stall}, 32'd0);
    chk("err_sticky", {31'd0, err}, 32'd1);
    issue_valid = 1'b0;
    tick();

    // Mid-stream reset with FIFO full, busy[5] set and a write in flight
    do_issue(5'd5); do_issue(5'd6); do_issue(5'd7);
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0;
    ld_valid = 1'b1; ld_rd = 5'd5; ld_data = 32'hBAD5;
    tick();
    alu_rd = 5'd7; alu_data = 32'h70; ld_rd = 5'd6; ld_data = 32'hBAD6;
    #1;
    chk("rst_pre_ld_ready1", {31'd0, ld_ready}, 32'd1);
    tick();
    idle_inputs();
    chk("rst_pre_we", {31'd0, reg_we}, 32'd1);
    chk("rst_pre_waddr", {27'd0, reg_waddr}, 32'd7);
    issue_valid = 1'b1; issue_rs1 = 5'd5; issue_rs2 = 5'd6; issue_rd = 5'd7;
    #1;
    chk("rst_pre_ld_ready_full", {31'd0, ld_ready}, 32'd0);
    chk("rst_pre_stall", {31'd0, issue_stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_we",       {31'd0, reg_we},      32'd0);
    chk("rst_async_waddr",    {27'd0, reg_waddr},   32'd0);
    chk("rst_async_wdata",    reg_wdata,            32'd0);
    chk("rst_async_ld_ready", {31'd0, ld_ready},    32'd1);
    chk("rst_async_stall",    {31'd0, issue_stall}, 32'd0);
    chk("rst_async_err",      {31'd0, err},         32'd0);
    issue_valid = 1'b0;
    tick();
    tick();
    chk("rst_held_ld_ready", {31'd0, ld_ready}, 32'd1);
    rst_n = 1'b1;
    do_issue(5'd11);
    ld_valid = 1'b1; ld_rd = 5'd11; ld_data = 32'h1111;
    #1;
    chk("post_rst_ld_ready", {31'd0, ld_ready}, 32'd1);
    tick();
    ld_valid = 1'b0;
    chk("post_rst_we",    {31'd0, reg_we},    32'd1);
    chk("post_rst_waddr", {27'd0, reg_waddr}, 32'd11);
    chk("post_rst_wdata", reg_wdata,          32'h1111);
    tick();
    chk("post_rst_no_stale_we", {31'd0, reg_we}, 32'd0);
    chk("post_rst_waddr_hold",  {27'd0, reg_waddr}, 32'd11);
    chk("post_rst_err",         {31'd0, err},    32'd0);
    issue_valid = 1'b1; issue_rs1 = 5'd5; issue_rs2 = 5'd6; issue_rd = 5'd11;
    #1;
    chk("post_rst_busy_clear", {31'd0, issue_stall}, 32'd0);
    issue_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
